// File: rtl/turbo_pkg.sv
// Shared constants and types for the rate-1/3 turbo encoder core.
// Tap vectors are LSB = D^0, so G0 = 1+D^2+D^3 and G1 = 1+D+D^3.
package turbo_pkg;

  localparam int DEFAULT_PERIOD     = 12;
  localparam int DEFAULT_TAIL_STEPS = 3;

  localparam logic [3:0] G0 = 4'b1101;
  localparam logic [3:0] G1 = 4'b1011;

  typedef enum logic [1:0] {
    IDLE,
    ENCODE,
    TERM,
    DONE
  } encState_t;

endpackage

// File: rtl/rsc_encoder.sv
// 8-state recursive systematic convolutional constituent encoder.
// x/z are combinational from the current state and input; the state advances on step_en.
module rsc_encoder
  import turbo_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic u,
  input  logic step_en,
  input  logic term,
  input  logic clear,
  output logic x,
  output logic z
);

  logic [2:0] s;  // s[0] is the newest delay element
  logic       fb;
  logic       uEff;
  logic       a;

  // NOTE: every signal written in this block gets a value on every path, so no latch is inferred.
  always_comb begin
    fb   = ^(G0[3:1] & s);
    // Feeding the feedback back in as the input forces a=0, draining the register to zero.
    uEff = term ? fb : u;
    a    = uEff ^ fb;
    x    = uEff;
    z    = (G1[0] & a) ^ (^(G1[3:1] & s));
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s <= '0;
    end else if (clear) begin
      s <= '0;
    end else if (step_en) begin
      s <= {s[1:0], a};
    end
  end

endmodule

// File: rtl/turbo_encoder_core.sv
// Rate-1/3 turbo encoder: two RSC encoders, one-entry input holding register,
// and a period timer that emits one registered 4-bit symbol per PERIOD clocks.
module turbo_encoder_core
  import turbo_pkg::*;
#(
  parameter int PERIOD     = DEFAULT_PERIOD,
  parameter int TAIL_STEPS = DEFAULT_TAIL_STEPS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_x,
  input  logic       in_xi,
  input  logic       in_last,
  input  logic       load,
  output logic       in_ready,
  output logic [3:0] out,
  output logic       validOut,
  output logic       mode,
  output logic       underrun
);

  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int TC_W  = $clog2(TAIL_STEPS + 1);

  encState_t  state;
  encState_t  stateNext;
  logic [CNT_W-1:0] cnt;
  logic [TC_W-1:0]  tailCnt;

  logic holdX;
  logic holdXi;
  logic holdLast;
  logic holdFull;

  logic boundary;
  logic accept;
  logic consume;
  logic starve;
  logic stepEn;
  logic termEn;
  logic clearEnc;

  logic x1;
  logic z1;
  logic x2;
  logic z2;

  assign boundary = (cnt == CNT_W'(PERIOD - 1));
  assign in_ready = !holdFull && (state == IDLE || state == ENCODE);
  assign accept   = load && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    consume   = 1'b0;
    starve    = 1'b0;
    stepEn    = 1'b0;
    termEn    = 1'b0;
    clearEnc  = 1'b0;
    unique case (state)
      IDLE, ENCODE: begin
        if (boundary) begin
          if (holdFull) begin
            consume   = 1'b1;
            stepEn    = 1'b1;
            stateNext = holdLast ? TERM : ENCODE;
          end else if (state == ENCODE) begin
            starve = 1'b1;
          end
        end
      end
      TERM: begin
        if (boundary) begin
          stepEn = 1'b1;
          termEn = 1'b1;
          if (tailCnt == TC_W'(TAIL_STEPS - 1)) begin
            stateNext = DONE;
          end
        end
      end
      DONE: begin
        if (boundary) begin
          clearEnc  = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // The timer parks at PERIOD-1 in IDLE so that every idle cycle is a boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= CNT_W'(PERIOD - 1);
      tailCnt <= '0;
    end else begin
      if (stateNext == IDLE) begin
        cnt <= CNT_W'(PERIOD - 1);
      end else if (state == IDLE || boundary) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (state != TERM) begin
        tailCnt <= '0;
      end else if (boundary) begin
        tailCnt <= tailCnt + 1'b1;
      end
    end
  end

  // An accept in the consuming cycle wins, leaving the entry full with the new bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      holdX    <= 1'b0;
      holdXi   <= 1'b0;
      holdLast <= 1'b0;
      holdFull <= 1'b0;
    end else if (accept) begin
      holdX    <= in_x;
      holdXi   <= in_xi;
      holdLast <= in_last;
      holdFull <= 1'b1;
    end else if (consume) begin
      holdFull <= 1'b0;
    end
  end

  rsc_encoder u_enc1 (
    .clk     (clk),
    .reset   (reset),
    .u       (holdX),
    .step_en (stepEn),
    .term    (termEn),
    .clear   (clearEnc),
    .x       (x1),
    .z       (z1)
  );

  rsc_encoder u_enc2 (
    .clk     (clk),
    .reset   (reset),
    .u       (holdXi),
    .step_en (stepEn),
    .term    (termEn),
    .clear   (clearEnc),
    .x       (x2),
    .z       (z2)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out      <= '0;
      validOut <= 1'b0;
      mode     <= 1'b0;
      underrun <= 1'b0;
    end else if (consume) begin
      out      <= {1'b0, z2, z1, x1};
      validOut <= 1'b1;
      mode     <= 1'b0;
    end else if (starve) begin
      validOut <= 1'b0;
      mode     <= 1'b0;
      underrun <= 1'b1;
    end else if (termEn) begin
      out      <= {x2, z2, z1, x1};
      validOut <= 1'b1;
      mode     <= 1'b1;
    end else if (clearEnc) begin
      validOut <= 1'b0;
      mode     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_turbo_encoder_core.sv
// Directed bench for turbo_encoder_core: table of per-period expected symbols
// plus hand-written reset, underrun and blocked-load sequences.
module tb_turbo_encoder_core;
  import turbo_pkg::*;

  localparam int P = DEFAULT_PERIOD;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_x;
  logic       in_xi;
  logic       in_last;
  logic       load;
  logic       in_ready;
  logic [3:0] out;
  logic       validOut;
  logic       mode;
  logic       underrun;

  turbo_encoder_core dut (
    .clk      (clk),
    .reset    (reset),
    .in_x     (in_x),
    .in_xi    (in_xi),
    .in_last  (in_last),
    .load     (load),
    .in_ready (in_ready),
    .out      (out),
    .validOut (validOut),
    .mode     (mode),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // One record per emitted period: doLoad=0 with expValid=1 is a tail, with expValid=0 a gap.
  typedef struct {
    bit         doLoad;
    logic       x;
    logic       xi;
    logic       last;
    logic [3:0] expOut;
    logic       expValid;
    logic       expMode;
  } vec_t;

  vec_t vecs[23];
  int   nVec = 0;
  int   nMis = 0;

  function automatic vec_t mk(bit d, logic x, logic xi, logic last,
                              logic [3:0] o, logic v, logic m);
    vec_t r;
    r.doLoad = d; r.x = x; r.xi = xi; r.last = last;
    r.expOut = o; r.expValid = v; r.expMode = m;
    return r;
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic waitCyc(input int target);
    int g = 0;
    while (cyc < target && g < 1000) begin
      @(negedge clk);
      g++;
    end
    if (cyc != target) begin
      nVec++;
      nMis++;
      $display("FAIL wait_cycle: reached cycle %0d, expected %0d", cyc, target);
    end
  endtask

  task automatic loadBit(input logic x, input logic xi, input logic last,
                         input bit junk, output int acc);
    int g = 0;
    while (!in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) begin
      nVec++;
      nMis++;
      $display("FAIL load_ready: in_ready got 0, expected 1");
    end
    load = 1'b1; in_x = x; in_xi = xi; in_last = last;
    @(posedge clk);
    #1;
    acc = cyc;
    if (junk) begin
      in_x = 1'b0; in_xi = 1'b1; in_last = 1'b0;
    end else begin
      load = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic runVectors(input int first, input int n, input bit complete, input bit junk);
    int         acc;
    int         emit;
    int         prevEmit;
    logic [3:0] prevOut;
    logic       prevValid;
    vec_t       v;
    prevEmit = 0; prevOut = '0; prevValid = 1'b0;
    for (int i = first; i < first + n; i++) begin
      v = vecs[i];
      if (i == first) begin
        loadBit(v.x, v.xi, v.last, junk, acc);
        check($sformatf("latency_early[%0d]", i), validOut, 1'b0);
        emit = acc + 1;
      end else begin
        if (v.doLoad) loadBit(v.x, v.xi, v.last, 1'b0, acc);
        emit = prevEmit + P;
        waitCyc(emit - 1);
        check($sformatf("hold_valid[%0d]", i), validOut, prevValid);
        if (prevValid) check($sformatf("hold_out[%0d]", i), out, prevOut);
      end
      waitCyc(emit);
      check($sformatf("valid[%0d]", i), validOut, v.expValid);
      if (v.expValid) begin
        check($sformatf("out[%0d]", i), out, v.expOut);
        check($sformatf("mode[%0d]", i), mode, v.expMode);
      end else begin
        check($sformatf("underrun[%0d]", i), underrun, 1'b1);
      end
      prevEmit = emit; prevOut = v.expOut; prevValid = v.expValid;
    end
    if (complete) begin
      waitCyc(prevEmit + P);
      check("done_valid", validOut, 1'b0);
      check("done_mode", mode, 1'b0);
      check("done_ready", in_ready, 1'b1);
      if (junk) load = 1'b0;
    end
  endtask

  initial begin
    int bad;
    // Block A: x == xi = 1,0,0 (last on third)
    vecs[0]  = mk(1, 1, 1, 0, 4'b0111, 1, 0);
    vecs[1]  = mk(1, 0, 0, 0, 4'b0110, 1, 0);
    vecs[2]  = mk(1, 0, 0, 1, 4'b0110, 1, 0);
    vecs[3]  = mk(0, 0, 0, 0, 4'b1001, 1, 1);
    vecs[4]  = mk(0, 0, 0, 0, 4'b1001, 1, 1);
    vecs[5]  = mk(0, 0, 0, 0, 4'b1111, 1, 1);
    // Block B: x = 1,1,0 and xi = 0,1,1
    vecs[6]  = mk(1, 1, 0, 0, 4'b0011, 1, 0);
    vecs[7]  = mk(1, 1, 1, 0, 4'b0101, 1, 0);
    vecs[8]  = mk(1, 0, 1, 1, 4'b0000, 1, 0);
    vecs[9]  = mk(0, 0, 0, 0, 4'b1100, 1, 1);
    vecs[10] = mk(0, 0, 0, 0, 4'b0110, 1, 1);
    vecs[11] = mk(0, 0, 0, 0, 4'b1111, 1, 1);
    // Block C: block A with one starved period after the first bit
    vecs[12] = mk(1, 1, 1, 0, 4'b0111, 1, 0);
    vecs[13] = mk(0, 0, 0, 0, 4'b0000, 0, 0);
    vecs[14] = mk(1, 0, 0, 0, 4'b0110, 1, 0);
    vecs[15] = mk(1, 0, 0, 1, 4'b0110, 1, 0);
    vecs[16] = mk(0, 0, 0, 0, 4'b1001, 1, 1);
    vecs[17] = mk(0, 0, 0, 0, 4'b1001, 1, 1);
    vecs[18] = mk(0, 0, 0, 0, 4'b1111, 1, 1);
    // Block D: single bit x == xi = 1
    vecs[19] = mk(1, 1, 1, 1, 4'b0111, 1, 0);
    vecs[20] = mk(0, 0, 0, 0, 4'b0110, 1, 1);
    vecs[21] = mk(0, 0, 0, 0, 4'b1001, 1, 1);
    vecs[22] = mk(0, 0, 0, 0, 4'b1111, 1, 1);

    reset = 1'b1; load = 1'b0; in_x = 1'b0; in_xi = 1'b0; in_last = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_out", out, 4'b0000);
    check("rst_valid", validOut, 1'b0);
    check("rst_mode", mode, 1'b0);
    check("rst_ready", in_ready, 1'b1);
    check("rst_underrun", underrun, 1'b0);
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (out !== 4'b0000 || validOut !== 1'b0) bad++;
    end
    check("idle_quiet_cycles", 4'(bad), 4'd0);

    runVectors(0, 6, 1'b1, 1'b0);
    runVectors(6, 6, 1'b1, 1'b0);
    runVectors(12, 7, 1'b1, 1'b0);
    check("underrun_sticky", underrun, 1'b1);

    // Asynchronous reset in the middle of the second tail symbol.
    runVectors(0, 5, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("midrst_out", out, 4'b0000);
    check("midrst_valid", validOut, 1'b0);
    check("midrst_mode", mode, 1'b0);
    check("midrst_underrun", underrun, 1'b0);
    check("midrst_ready", in_ready, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Single-bit block with load held high through TERM/DONE.
    runVectors(19, 4, 1'b1, 1'b1);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (validOut !== 1'b0) bad++;
    end
    check("no_spurious_symbol", 4'(bad), 4'd0);
    check("ready_after_block", in_ready, 1'b1);
    runVectors(6, 6, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
